alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter width_p, default 8, which sets the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n_i, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port v_i, input, 1 bit, meaning operands and select are valid this cycle.
REQ-005 The block SHALL have port sel_i, input, 2 bits, the operation select.
REQ-006 The block SHALL have port a_i, input, width_p bits, operand A (unsigned).
REQ-007 The block SHALL have port b_i, input, width_p bits, operand B (unsigned).
REQ-008 The block SHALL have port res_o, output, width_p bits, the registered result.
REQ-009 The block SHALL have port v_o, output, 1 bit, meaning res_o and the flags hold a newly computed result.
REQ-010 The block SHALL have port carry_o, output, 1 bit, the registered carry/borrow flag.
REQ-011 The block SHALL have port zero_o, output, 1 bit, the registered zero flag.

Function
REQ-012 The operation SHALL be selected by sel_i:
- 2'b00: ADD, res = (a_i + b_i) mod 2^width_p
- 2'b01: SUB, res = (a_i - b_i) mod 2^width_p
- 2'b10: AND, bitwise
- 2'b11: OR, bitwise
REQ-013 For ADD, carry SHALL be bit width_p of the (width_p+1)-bit sum.
REQ-014 For SUB, carry SHALL be the borrow, equal to 1 exactly when a_i < b_i (unsigned).
REQ-015 For AND and OR, carry SHALL be 0.
REQ-016 zero SHALL be 1 exactly when the width_p-bit result equals 0.
REQ-017 Latency SHALL be 1 cycle: when v_i=1 at a rising edge with reset_n_i=1, res_o, carry_o and zero_o take that cycle's result and v_o=1 after the edge.
REQ-018 When v_i=0 at a rising edge (reset_n_i=1), res_o, carry_o and zero_o SHALL hold their previous values and v_o SHALL be 0.
REQ-019 There is no backpressure: a new operation SHALL be accepted every cycle v_i=1, and back-to-back operations SHALL produce back-to-back results.
REQ-020 Outputs SHALL be driven only from registers, with no combinational path from any input to any output.
REQ-021 Wrap-around SHALL be silent (modulo 2^width_p), with overflow reported only through carry_o.

Reset
REQ-022 When reset_n_i=0 at a rising edge, res_o SHALL become 0, carry_o 0, zero_o 1 and v_o 0, regardless of v_i.
REQ-023 An operation presented in the same cycle as an asserted reset SHALL be discarded.
REQ-024 After reset_n_i deasserts, the first result SHALL appear one cycle after the first v_i=1 edge.
REQ-025 Outputs SHALL be defined (non-X) from the first reset edge onward.

Verification (width_p=8)
REQ-026 ADD: sel=00, a=0x01, b=0x03, v_i=1 -> next cycle res_o=0x04, carry_o=0, zero_o=0, v_o=1.
REQ-027 SUB borrow: sel=01, a=0x01, b=0x03 -> res_o=0xFE, carry_o=1, zero_o=0.
REQ-028 Logic: sel=10, a=0xF0, b=0x3C -> res_o=0x30; then sel=11 with the same operands -> res_o=0xFC; carry_o=0 for both.
REQ-029 ADD wrap: sel=00, a=0xFF, b=0x01 -> res_o=0x00, carry_o=1, zero_o=1.
REQ-030 Sweep: sel 00->01->10->11 on consecutive cycles with a=0x01, b=0x03 -> results 0x04, 0xFE, 0x01, 0x03 on consecutive cycles with v_o held at 1.
REQ-031 Reset mid-stream: reset_n_i=0 while v_i=1 -> next cycle res_o=0x00, zero_o=1, carry_o=0, v_o=0; then v_i=0 -> outputs hold.

Source files
------------

// File: rtl/alu.sv
// Registered two-operand ALU: ADD/SUB/AND/OR with carry/borrow and zero flags.
// The result registers hold their value on idle cycles; v_o pulses once per result.
module alu #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [1:0]         sel_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] res_o,
  output logic               v_o,
  output logic               carry_o,
  output logic               zero_o
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  logic [width_p:0]   sum_ext;
  logic [width_p:0]   diff_ext;
  logic [width_p-1:0] alu_res;
  logic               alu_carry;

  logic [width_p-1:0] res_q, res_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               v_q, v_d;

  // The extra MSB of the extended difference is set exactly when a_i < b_i.
  assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_e'(sel_i))
      OP_ADD: begin
        alu_res   = sum_ext[width_p-1:0];
        alu_carry = sum_ext[width_p];
      end
      OP_SUB: begin
        alu_res   = diff_ext[width_p-1:0];
        alu_carry = diff_ext[width_p];
      end
      OP_AND: alu_res = a_i & b_i;
      OP_OR:  alu_res = a_i | b_i;
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    v_d     = 1'b0;
    if (v_i) begin
      res_d   = alu_res;
      carry_d = alu_carry;
      zero_d  = (alu_res == '0);
      v_d     = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      v_q     <= v_d;
    end
  end

  assign res_o   = res_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;
  assign v_o     = v_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu (width_p=8): stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever v_o is high.
module tb_alu;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic [1:0]   sel_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] res_o;
  logic         v_o;
  logic         carry_o;
  logic         zero_o;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  alu #(.width_p(W)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .sel_i     (sel_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .res_o     (res_o),
    .v_o       (v_o),
    .carry_o   (carry_o),
    .zero_o    (zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid result must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk_i);
      if (v_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_v_o: got result 0x%0h with empty scoreboard", res_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, ".res"},   64'(res_o),   64'(e.res));
          check({e.name, ".carry"}, 64'(carry_o), 64'(e.carry));
          check({e.name, ".zero"},  64'(zero_o),  64'(e.zero));
        end
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic carry,
                       input logic zero);
    exp_t e;
    e.name  = name;
    e.res   = res;
    e.carry = carry;
    e.zero  = zero;
    exp_q.push_back(e);
    v_i   = 1'b1;
    sel_i = sel;
    a_i   = a;
    b_i   = b;
    @(posedge clk_i);
    #1;
    check({name, ".v_o"}, 64'(v_o), 64'd1);
  endtask

  task automatic idle();
    v_i = 1'b0;
    a_i = 8'hA5;
    b_i = 8'h5A;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [W-1:0] res, input logic carry,
                               input logic zero, input logic v);
    check({name, ".res"},   64'(res_o),   64'(res));
    check({name, ".carry"}, 64'(carry_o), 64'(carry));
    check({name, ".zero"},  64'(zero_o),  64'(zero));
    check({name, ".v_o"},   64'(v_o),     64'(v));
  endtask

  initial begin
    // Reset with a live operation on the inputs; it must be discarded.
    reset_n_i = 1'b0;
    v_i       = 1'b1;
    sel_i     = 2'b00;
    a_i       = 8'h12;
    b_i       = 8'h34;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("reset", 8'h00, 1'b0, 1'b1, 1'b0);
    reset_n_i = 1'b1;
    idle();
    check_outputs("post_reset_idle", 8'h00, 1'b0, 1'b1, 1'b0);

    issue("add",      2'b00, 8'h01, 8'h03, 8'h04, 1'b0, 1'b0);
    issue("sub_borr", 2'b01, 8'h01, 8'h03, 8'hFE, 1'b1, 1'b0);
    issue("and",      2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    issue("or",       2'b11, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
    issue("add_wrap", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    issue("sub_eq",   2'b01, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1);
    issue("sub_max",  2'b01, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    issue("and_zero", 2'b10, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1);
    idle();
    check_outputs("hold_after_and", 8'h00, 1'b0, 1'b1, 1'b0);

    // Back-to-back sweep over all four operations.
    issue("sweep_add", 2'b00, 8'h01, 8'h03, 8'h04, 1'b0, 1'b0);
    issue("sweep_sub", 2'b01, 8'h01, 8'h03, 8'hFE, 1'b1, 1'b0);
    issue("sweep_and", 2'b10, 8'h01, 8'h03, 8'h01, 1'b0, 1'b0);
    issue("sweep_or",  2'b11, 8'h01, 8'h03, 8'h03, 1'b0, 1'b0);
    idle();
    check_outputs("hold_after_sweep", 8'h03, 1'b0, 1'b0, 1'b0);
    idle();
    check_outputs("hold_2", 8'h03, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream while an operation is presented.
    issue("pre_rst", 2'b01, 8'h01, 8'h03, 8'hFE, 1'b1, 1'b0);
    reset_n_i = 1'b0;
    v_i       = 1'b1;
    sel_i     = 2'b00;
    a_i       = 8'h10;
    b_i       = 8'h20;
    @(posedge clk_i);
    #1;
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b1, 1'b0);
    reset_n_i = 1'b1;
    idle();
    check_outputs("mid_reset_hold", 8'h00, 1'b0, 1'b1, 1'b0);
    issue("first_after_rst", 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
    idle();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk_i);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
